// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receiver:
// parity modes, FSM states and a clog2 helper.
package uart_rx_fifo_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_rx_sync_fifo.sv
// First-word-fall-through receive FIFO.
// Head reads as zero while empty.
module rx_sync_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_rd,
  output logic [W-1:0] o_rdata,
  output logic         o_empty,
  output logic         o_full,
  output logic         o_drop
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_pop;
  logic         w_push;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = i_rd && !o_empty;
  assign w_push  = i_wr && (!o_full || w_pop);
  assign o_drop  = i_wr && o_full && !w_pop;
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  // pointer update; a pop frees the slot a same-cycle push needs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // storage write
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority vote,
// optional parity, sticky error flags and an rx FIFO.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rxd,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 fifo_full,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 err_clr
);

  localparam int SR  = BAUD * OVERSAMPLE;
  localparam int DIV = (CLK_HZ + SR / 2) / SR;
  localparam int DW  = clog2(DIV + 1);
  localparam int TW  = clog2(OVERSAMPLE + 1);
  localparam int BW  = clog2(DATA_BITS + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_S0     = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1     = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_S2     = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] B_LAST   = BW'(DATA_BITS - 1);

  logic [1:0]           r_sync;
  logic                 r_rx_q;
  logic [DW-1:0]        r_div;
  logic [TW-1:0]        r_tcnt;
  logic                 r_s0;
  logic                 r_s1;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  state_t               r_state;

  logic w_rx;
  logic w_fall;
  logic w_tick;
  logic w_dec;
  logic w_vote;
  logic w_par;
  logic w_par_bad;
  logic w_push;
  logic w_empty;
  logic w_drop;
  logic w_ferr_ev;
  logic w_perr_ev;

  assign w_rx   = r_sync[1];
  assign w_fall = r_rx_q & ~w_rx;
  assign w_tick = (r_div == DIV_LAST);
  assign w_dec  = w_tick && (r_tcnt == T_S2);
  assign w_vote = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);

  assign w_par     = ^{r_shift, w_vote};
  assign w_par_bad = (PARITY == PAR_ODD) ? ~w_par : w_par;

  assign w_push    = (r_state == S_STOP) && w_dec && w_vote && !r_perr;
  assign w_ferr_ev = (r_state == S_STOP) && w_dec && !w_vote;
  assign w_perr_ev = (r_state == S_PARITY) && w_dec && w_par_bad;

  assign busy     = (r_state != S_IDLE);
  assign rd_valid = ~w_empty;

  // two-stage synchroniser plus delayed copy for edge detect
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync <= 2'b11;
      r_rx_q <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], rxd};
      r_rx_q <= w_rx;
    end
  end

  // tick divider and tick-in-bit counter, realigned on start edge
  always_ff @(posedge clock) begin
    if (!reset_n || (r_state == S_IDLE && w_fall)) begin
      r_div  <= '0;
      r_tcnt <= '0;
    end else if (w_tick) begin
      r_div  <= '0;
      r_tcnt <= (r_tcnt == OS_LAST) ? '0 : r_tcnt + TW'(1);
    end else begin
      r_div  <= r_div + DW'(1);
    end
  end

  // capture the first two of the three vote samples
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else if (w_tick) begin
      if (r_tcnt == T_S0) r_s0 <= w_rx;
      if (r_tcnt == T_S1) r_s1 <= w_rx;
    end
  end

  // frame FSM: decisions taken on the third vote sample
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_bit   <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_fall) begin
          r_state <= S_START;
          r_bit   <= '0;
          r_perr  <= 1'b0;
        end
        S_START: if (w_dec) begin
          r_state <= w_vote ? S_IDLE : S_DATA;
        end
        S_DATA: if (w_dec) begin
          r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
          r_bit   <= r_bit + BW'(1);
          if (r_bit == B_LAST)
            r_state <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
        end
        S_PARITY: if (w_dec) begin
          r_perr  <= w_par_bad;
          r_state <= S_STOP;
        end
        S_STOP: if (w_dec) begin
          r_state <= w_vote ? S_IDLE : S_BREAK;
        end
        S_BREAK: if (w_rx) begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // sticky flags; a same-cycle event beats err_clr
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (err_clr) begin
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
        overrun    <= 1'b0;
      end
      if (w_ferr_ev) frame_err  <= 1'b1;
      if (w_perr_ev) parity_err <= 1'b1;
      if (w_drop)    overrun    <= 1'b1;
    end
  end

  rx_sync_fifo #(
    .W     (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_wr    (w_push),
    .i_wdata (r_shift),
    .i_rd    (rd_en),
    .o_rdata (rd_data),
    .o_empty (w_empty),
    .o_full  (fifo_full),
    .o_drop  (w_drop)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: default, fast
// (160 clk/bit) and fast even-parity instances.
module tb_uart_rx_fifo;

  localparam int BT_D = 1250;
  localparam int BT_F = 160;

  logic clk = 1'b0;
  logic rst_n;
  logic rxd_d, rxd_f, rxd_p;
  logic rd_d, rd_f, rd_p;
  logic clr_d, clr_f, clr_p;

  logic [7:0] dat_d, dat_f, dat_p;
  logic val_d, val_f, val_p;
  logic full_d, full_f, full_p;
  logic busy_d, busy_f, busy_p;
  logic fe_d, fe_f, fe_p;
  logic pe_d, pe_f, pe_p;
  logic ov_d, ov_f, ov_p;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];
  logic [7:0] e;

  always #5 clk = ~clk;

  uart_rx_fifo u_def (
    .clock(clk), .reset_n(rst_n), .rxd(rxd_d), .rd_en(rd_d),
    .rd_data(dat_d), .rd_valid(val_d), .fifo_full(full_d),
    .busy(busy_d), .frame_err(fe_d), .parity_err(pe_d),
    .overrun(ov_d), .err_clr(clr_d)
  );

  uart_rx_fifo #(.CLK_HZ(1536000)) u_fast (
    .clock(clk), .reset_n(rst_n), .rxd(rxd_f), .rd_en(rd_f),
    .rd_data(dat_f), .rd_valid(val_f), .fifo_full(full_f),
    .busy(busy_f), .frame_err(fe_f), .parity_err(pe_f),
    .overrun(ov_f), .err_clr(clr_f)
  );

  uart_rx_fifo #(.CLK_HZ(1536000), .PARITY(2)) u_par (
    .clock(clk), .reset_n(rst_n), .rxd(rxd_p), .rd_en(rd_p),
    .rd_data(dat_p), .rd_valid(val_p), .fifo_full(full_p),
    .busy(busy_p), .frame_err(fe_p), .parity_err(pe_p),
    .overrun(ov_p), .err_clr(clr_p)
  );

  task automatic drive(input int w, input logic v, input int n);
    case (w)
      0: rxd_d = v;
      1: rxd_f = v;
      default: rxd_p = v;
    endcase
    repeat (n) @(negedge clk);
  endtask

  // par < 0: no parity bit; stop_low > 0: stop held low that many bits
  task automatic send(input int w, input logic [7:0] d,
                      input int par, input int stop_low, input int bt);
    drive(w, 1'b0, bt);
    for (int i = 0; i < 8; i++) drive(w, d[i], bt);
    if (par >= 0) drive(w, par[0], bt);
    if (stop_low > 0) drive(w, 1'b0, stop_low * bt);
    drive(w, 1'b1, bt);
  endtask

  task automatic test_reset;
    n_vec++;
    if ({dat_d, val_d, full_d, busy_d, fe_d, pe_d, ov_d} !== 14'h0) begin
      n_err++;
      $display("FAIL reset_def: got %h want 0",
               {dat_d, val_d, full_d, busy_d, fe_d, pe_d, ov_d});
    end
    n_vec++;
    if ({dat_f, val_f, full_f, busy_f, fe_f, pe_f, ov_f} !== 14'h0) begin
      n_err++;
      $display("FAIL reset_fast: got %h want 0",
               {dat_f, val_f, full_f, busy_f, fe_f, pe_f, ov_f});
    end
    n_vec++;
    if ({dat_p, val_p, full_p, busy_p, fe_p, pe_p, ov_p} !== 14'h0) begin
      n_err++;
      $display("FAIL reset_par: got %h want 0",
               {dat_p, val_p, full_p, busy_p, fe_p, pe_p, ov_p});
    end
  endtask

  task automatic test_default_55;
    exp_q.push_back(8'h55);
    send(0, 8'h55, -1, 0, BT_D);
    e = exp_q.pop_front();
    n_vec++;
    if ({val_d, dat_d} !== {1'b1, e}) begin
      n_err++;
      $display("FAIL def_rx: got %b/%h want 1/%h", val_d, dat_d, e);
    end
    n_vec++;
    if ({fe_d, pe_d, ov_d} !== 3'b000) begin
      n_err++;
      $display("FAIL def_flags: got %b want 000", {fe_d, pe_d, ov_d});
    end
    @(negedge clk) rd_d = 1'b1;
    @(negedge clk) rd_d = 1'b0;
    n_vec++;
    if (val_d !== 1'b0) begin
      n_err++;
      $display("FAIL def_pop: rd_valid got %b want 0", val_d);
    end
  endtask

  task automatic test_glitch;
    drive(1, 1'b0, 3);
    drive(1, 1'b1, 6);
    n_vec++;
    if (busy_f !== 1'b1) begin
      n_err++;
      $display("FAIL glitch_busy_hi: got %b want 1", busy_f);
    end
    repeat (BT_F) @(negedge clk);
    n_vec++;
    if ({busy_f, val_f} !== 2'b00) begin
      n_err++;
      $display("FAIL glitch_idle: busy/valid got %b want 00",
               {busy_f, val_f});
    end
  endtask

  task automatic test_frame_err;
    send(1, 8'hA3, -1, 2, BT_F);
    n_vec++;
    if ({fe_f, val_f} !== 2'b10) begin
      n_err++;
      $display("FAIL ferr_set: fe/valid got %b want 10", {fe_f, val_f});
    end
    exp_q.push_back(8'h3C);
    send(1, 8'h3C, -1, 0, BT_F);
    e = exp_q.pop_front();
    n_vec++;
    if ({val_f, dat_f} !== {1'b1, e}) begin
      n_err++;
      $display("FAIL ferr_next: got %b/%h want 1/%h", val_f, dat_f, e);
    end
    @(negedge clk) begin rd_f = 1'b1; clr_f = 1'b1; end
    @(negedge clk) begin rd_f = 1'b0; clr_f = 1'b0; end
    n_vec++;
    if ({fe_f, val_f} !== 2'b00) begin
      n_err++;
      $display("FAIL ferr_clr: fe/valid got %b want 00", {fe_f, val_f});
    end
  endtask

  task automatic test_parity;
    send(2, 8'h07, 0, 0, BT_F);
    n_vec++;
    if ({pe_p, val_p} !== 2'b10) begin
      n_err++;
      $display("FAIL par_bad: pe/valid got %b want 10", {pe_p, val_p});
    end
    exp_q.push_back(8'h07);
    send(2, 8'h07, 1, 0, BT_F);
    e = exp_q.pop_front();
    n_vec++;
    if ({val_p, dat_p, fe_p} !== {1'b1, e, 1'b0}) begin
      n_err++;
      $display("FAIL par_good: got %b/%h fe=%b want 1/%h fe=0",
               val_p, dat_p, fe_p, e);
    end
  endtask

  task automatic test_overrun;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send(1, 8'(i), -1, 0, BT_F);
    end
    n_vec++;
    if ({ov_f, full_f} !== 2'b11) begin
      n_err++;
      $display("FAIL ovr_set: ov/full got %b want 11", {ov_f, full_f});
    end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_vec++;
      if ({val_f, dat_f} !== {1'b1, e}) begin
        n_err++;
        $display("FAIL ovr_pop%0d: got %b/%h want 1/%h",
                 i, val_f, dat_f, e);
      end
      @(negedge clk) rd_f = 1'b1;
      @(negedge clk) rd_f = 1'b0;
    end
    n_vec++;
    if ({val_f, full_f} !== 2'b00) begin
      n_err++;
      $display("FAIL ovr_empty: valid/full got %b want 00",
               {val_f, full_f});
    end
    @(negedge clk) clr_f = 1'b1;
    @(negedge clk) clr_f = 1'b0;
    n_vec++;
    if ({fe_f, pe_f, ov_f} !== 3'b000) begin
      n_err++;
      $display("FAIL ovr_clr: got %b want 000", {fe_f, pe_f, ov_f});
    end
  endtask

  task automatic test_reset_midframe;
    send(1, 8'h99, -1, 0, BT_F);
    n_vec++;
    if ({val_f, dat_f} !== {1'b1, 8'h99}) begin
      n_err++;
      $display("FAIL rst_pre: got %b/%h want 1/99", val_f, dat_f);
    end
    drive(1, 1'b0, BT_F);
    drive(1, 1'b1, 4 * BT_F + BT_F / 2);
    n_vec++;
    if (busy_f !== 1'b1) begin
      n_err++;
      $display("FAIL rst_busy: got %b want 1", busy_f);
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({dat_f, val_f, full_f, busy_f, fe_f, pe_f, ov_f} !== 14'h0) begin
      n_err++;
      $display("FAIL rst_mid: got %h want 0",
               {dat_f, val_f, full_f, busy_f, fe_f, pe_f, ov_f});
    end
    rst_n = 1'b1;
    repeat (6 * BT_F) @(negedge clk);
    n_vec++;
    if ({busy_f, val_f} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_after: busy/valid got %b want 00",
               {busy_f, val_f});
    end
    exp_q.push_back(8'h12);
    send(1, 8'h12, -1, 0, BT_F);
    e = exp_q.pop_front();
    n_vec++;
    if ({val_f, dat_f, fe_f, pe_f, ov_f} !== {1'b1, e, 3'b000}) begin
      n_err++;
      $display("FAIL rst_next: got %b/%h/%b want 1/%h/000",
               val_f, dat_f, {fe_f, pe_f, ov_f}, e);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {rxd_d, rxd_f, rxd_p} = 3'b111;
    {rd_d, rd_f, rd_p} = 3'b000;
    {clr_d, clr_f, clr_p} = 3'b000;
    repeat (4) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    test_default_55();
    test_glitch();
    test_frame_err();
    test_parity();
    test_overrun();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
